// File: rtl/shift_reg_univ_if.sv
// Bundles the shift register control, data and status signals.
// Master drives operation controls; slave (the register) returns state.
// No handshake: the register accepts a new operation on every clock edge.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
);
  logic             en;
  logic [2:0]       mode;
  logic             sin_lo;
  logic             sin_hi;
  logic [WIDTH-1:0] pdin;
  logic [WIDTH-1:0] q;
  logic             sout_hi;
  logic             sout_lo;
  logic [CNTW-1:0]  shift_cnt;
  logic             word_done;
  logic             parity;

  modport master (
    output en, mode, sin_lo, sin_hi, pdin,
    input  q, sout_hi, sout_lo, shift_cnt, word_done, parity
  );

  modport slave (
    input  en, mode, sin_lo, sin_hi, pdin,
    output q, sout_hi, sout_lo, shift_cnt, word_done, parity
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/shift/rotate/load/clear with word counter.
// Latency: q, shift_cnt, word_done and parity update one edge after sampling.
// No backpressure; optional parity register under SHIFT_REG_UNIV_PARITY_EN.
module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNTW      = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  shift_reg_univ_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHUP  = 3'b001;
  localparam logic [2:0] MODE_SHDN  = 3'b010;
  localparam logic [2:0] MODE_ROTUP = 3'b011;
  localparam logic [2:0] MODE_ROTDN = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLR   = 3'b110;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  // Next-state: data path selection by mode, plus word counter and wrap pulse
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_SHUP: begin
          q_d      = {q_q[WIDTH-2:0], bus.sin_lo};
          shifting = 1'b1;
        end
        MODE_SHDN: begin
          q_d      = {bus.sin_hi, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_ROTUP: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shifting = 1'b1;
        end
        MODE_ROTDN: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.pdin;
          cnt_d = '0;
        end
        MODE_CLR: begin
          q_d   = RESET_VAL;
          cnt_d = '0;
        end
        MODE_HOLD: ;
        default: ;  // reserved encoding behaves as hold
      endcase
      // Direction changes do not restart the count; only load/clear/wrap do
      if (shifting) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.sout_hi   = q_q[WIDTH-1];
  assign bus.sout_lo   = q_q[0];
  assign bus.shift_cnt = cnt_q;
  assign bus.word_done = done_q;

`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks the next q so it is always consistent with the current q
  always_comb begin
    parity_d = ^q_d;
  end

  // Parity register, reset to the parity of RESET_VAL
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity_q <= ^RESET_VAL;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed test of shift_reg_univ at WIDTH=8 with hand-computed vectors.
// Inputs change 1ns after each rising edge; outputs are checked there too.
// Parity expectations follow SHIFT_REG_UNIV_PARITY_EN when it is defined.
module tb_shift_reg_univ;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  shift_reg_univ_if #(.WIDTH(8)) bus ();

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one operation and advance past the next rising edge
  task automatic cyc(input logic e, input logic [2:0] m, input logic sl,
                     input logic sh, input logic [7:0] pd);
    bus.en     = e;
    bus.mode   = m;
    bus.sin_lo = sl;
    bus.sin_hi = sh;
    bus.pdin   = pd;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] eq,
                            input logic [3:0] ecnt, input logic edone);
    logic ep;
`ifdef SHIFT_REG_UNIV_PARITY_EN
    ep = ^eq;
`else
    ep = 1'b0;
`endif
    chk({tag, ".q"},       64'(bus.q),         64'(eq));
    chk({tag, ".cnt"},     64'(bus.shift_cnt), 64'(ecnt));
    chk({tag, ".done"},    64'(bus.word_done), 64'(edone));
    chk({tag, ".sout_hi"}, 64'(bus.sout_hi),   64'(eq[7]));
    chk({tag, ".sout_lo"}, 64'(bus.sout_lo),   64'(eq[0]));
    chk({tag, ".parity"},  64'(bus.parity),    64'(ep));
  endtask

  logic [7:0] seq_up1 [8] = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
  logic [7:0] seq_up0 [8] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.en = 1'b1; bus.mode = 3'b101; bus.sin_lo = 1'b0; bus.sin_hi = 1'b0; bus.pdin = 8'hFF;

    // Reset overrides a pending load
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'hFF);
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'hFF);
    expect_all("reset", 8'h00, 4'd0, 1'b0);
    reset_n = 1'b1;

    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'hA5);
    expect_all("load_a5", 8'hA5, 4'd0, 1'b0);

    // Full word of shift-up with sin_lo=1, then a back-to-back word with sin_lo=0
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
      expect_all($sformatf("shup1_%0d", i), seq_up1[i], 4'((i + 1) % 8), (i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
      expect_all($sformatf("shup0_%0d", i), seq_up0[i], 4'((i + 1) % 8), (i == 7));
    end

    // Rotates keep counting across direction changes
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
    cyc(1'b1, 3'b100, 1'b0, 1'b0, 8'h00);
    expect_all("rotdn", 8'hC0, 4'd1, 1'b0);
    cyc(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
    expect_all("rotup1", 8'h81, 4'd2, 1'b0);
    cyc(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
    expect_all("rotup2", 8'h03, 4'd3, 1'b0);

    // Reset mid-word discards the partial count
    reset_n = 1'b0;
    cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    reset_n = 1'b1;
    expect_all("reset_mid", 8'h00, 4'd0, 1'b0);

    // Shift down with sin_hi
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'h3C);
    cyc(1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
    expect_all("shdn", 8'h9E, 4'd1, 1'b0);

    // 5 shifts, freeze with en=0, then finish the word
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    expect_all("shift5", 8'h1F, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'b001, 1'b1, 1'b0, 8'h00);
      expect_all($sformatf("frozen_%0d", i), 8'h1F, 4'd5, 1'b0);
    end
    cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    expect_all("resume1", 8'h3F, 4'd6, 1'b0);
    cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    expect_all("resume2", 8'h7F, 4'd7, 1'b0);
    cyc(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    expect_all("resume3", 8'hFF, 4'd0, 1'b1);

    // Load on the would-be wrap cycle: no pulse, count cleared
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
    expect_all("cnt7", 8'h00, 4'd7, 1'b0);
    cyc(1'b1, 3'b101, 1'b1, 1'b1, 8'h3C);
    expect_all("load_on_wrap", 8'h3C, 4'd0, 1'b0);
    cyc(1'b1, 3'b111, 1'b1, 1'b1, 8'hFF);
    expect_all("reserved", 8'h3C, 4'd0, 1'b0);
    cyc(1'b1, 3'b000, 1'b1, 1'b1, 8'hFF);
    expect_all("hold", 8'h3C, 4'd0, 1'b0);

    // Parity vectors (parity expected 0 throughout when the feature is off)
    cyc(1'b1, 3'b101, 1'b0, 1'b0, 8'h07);
    expect_all("par_load", 8'h07, 4'd0, 1'b0);
    cyc(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
    expect_all("par_shift", 8'h0E, 4'd1, 1'b0);
    cyc(1'b1, 3'b110, 1'b0, 1'b0, 8'hFF);
    expect_all("par_clear", 8'h00, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register. It is the next generation of the fixed 4-bit serial-in shift register.
- Width is set by parameter. Supports hold, shift up/down, rotate up/down, parallel load and synchronous clear.
- Tracks the number of shifts since the last load and pulses when a full word has been shifted, for use as a serializer/deserializer stage in datapath front-ends.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value of q after reset and after a clear (WIDTH bits).
- CNTW, $clog2(WIDTH+1), width of shift_cnt (derived; do not override).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- en  in  1  operation enable; when 0, all state holds (reset_n still acts)
- mode  in  3  operation select, see Behaviour
- sin_lo  in  1  serial input into bit 0 during shift up
- sin_hi  in  1  serial input into bit WIDTH-1 during shift down
- pdin  in  WIDTH  parallel load data
- q  out  WIDTH  register contents
- sout_hi  out  1  equals q[WIDTH-1] (combinational from q)
- sout_lo  out  1  equals q[0] (combinational from q)
- shift_cnt  out  CNTW  shifts/rotates performed since last load/clear/wrap
- word_done  out  1  one-cycle pulse after the WIDTH-th shift
- parity  out  1  see Optional Feature

Behaviour:
- Reset:
  - Sampled on the rising edge of clock. It does not act asynchronously.
  - reset_n=0 at an edge: q=RESET_VAL, shift_cnt=0, word_done=0, parity per feature.
  - Reset overrides en and mode. A reset mid-word discards the partial count.
- All state updates only on the rising edge of clock. With en=0, q and shift_cnt hold and word_done is 0.
- Modes (applied when en=1):
  - 000 hold: q unchanged, shift_cnt unchanged.
  - 001 shift up: q[i]<=q[i-1] for i=1..WIDTH-1; q[0]<=sin_lo.
  - 010 shift down: q[i]<=q[i+1] for i=0..WIDTH-2; q[WIDTH-1]<=sin_hi.
  - 011 rotate up: as shift up, but q[0]<=q[WIDTH-1].
  - 100 rotate down: as shift down, but q[WIDTH-1]<=q[0].
  - 101 parallel load: q<=pdin; shift_cnt<=0.
  - 110 clear: q<=RESET_VAL; shift_cnt<=0.
  - 111 reserved: behaves exactly as hold.
- Counter (modes 001..100 with en=1):
  - If shift_cnt==WIDTH-1: shift_cnt<=0 and word_done<=1 on the same edge.
  - Otherwise: shift_cnt<=shift_cnt+1.
  - Direction changes mid-word do not reset the count.
- word_done:
  - Registered. High for exactly one cycle following the edge of the WIDTH-th shift.
  - Any other cycle it is 0, including load/clear/hold.
  - Back-to-back words give one pulse every WIDTH shifting cycles, with no dead cycle.
- Latency: q reflects an operation one cycle after the edge that samples it. sout_hi/sout_lo follow q with zero latency.
- Load and clear always reset shift_cnt to 0, even if they occur on the cycle a wrap would have happened. In that case no word_done pulse.
- Inputs pdin/sin_* are ignored in modes that do not use them.

Optional Feature:
- Macro SHIFT_REG_UNIV_PARITY_EN.
- Defined:
  - parity is a register equal to the XOR-reduction of q, updated on the same edge as q, so it is always consistent with the current q.
  - Reset and clear set it to the XOR of RESET_VAL.
- Undefined: parity is tied to 0 and no parity register exists.

Test Plan:
- WIDTH=8, reset_n=0 for 2 edges with en=1 and mode=101, pdin=8'hFF -> q=8'h00, shift_cnt=0, word_done=0. Release, load 8'hA5 -> q=8'hA5 next cycle.
- q=8'hA5, 8 shift-up cycles with sin_lo=1 -> q sequence 4B,97,2F,5F,BF,7F,FF,FF. word_done high only in the cycle after the 8th edge; shift_cnt 1..7 then 0.
- q=8'h81, rotate down x1 -> 8'hC0. Rotate up x2 -> 8'h03. shift_cnt=3, no word_done.
- Shift 5 times, then en=0 for 3 cycles with mode=001 -> q and shift_cnt frozen at 5. Then 3 more shifts -> word_done pulse on the 3rd.
- shift_cnt=7 and mode=101 (pdin=8'h3C) -> q=8'h3C, shift_cnt=0, no word_done. mode=111 -> q stays 8'h3C.
- With SHIFT_REG_UNIV_PARITY_EN, load 8'h07 -> parity=1. Shift up with sin_lo=0 -> 8'h0E, parity=1. Clear -> parity=0. Without the macro, parity is 0 throughout.
